// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage; issues loads/stores over a variable-latency
// handshake, stalls upstream while waiting, and registers the MEM/WB result.
module mem_stage #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] aluResult1_PR,
   input  logic [31:0] readDataB1_PR,
   input  logic [31:0] Instr1_PR,
   input  logic [4:0]  writeRegister1_PR,
   input  logic        do_writeback1_PR,
   input  logic        MemRead1_PR,
   input  logic        MemWrite1_PR,
   input  logic        MemtoReg1_PR,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        Stall_MEM,
   output logic [31:0] Data1_MEM,
   output logic [4:0]  writeRegister1_MEM,
   output logic        do_writeback1_MEM,
   output logic [31:0] Data1_WB,
   output logic [4:0]  writeRegister1_WB,
   output logic        do_writeback1_WB,
   output logic        misalign_exc,
   output logic        bus_err
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t r_state, w_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic [5:0]  w_op;
   logic        w_byte, w_half, w_word, w_sext, w_mem, w_mis, w_req, w_stall, w_abort, w_timeout;
   logic [31:0] w_bsh, w_hsh, w_load;
   logic        w_unused;
   assign w_unused  = ^Instr1_PR[25:0];
   assign w_op      = Instr1_PR[31:26];
   assign w_byte    = (w_op == 6'h20) | (w_op == 6'h24) | (w_op == 6'h28);
   assign w_half    = (w_op == 6'h21) | (w_op == 6'h25) | (w_op == 6'h29);
   assign w_word    = ~w_byte & ~w_half;
   assign w_sext    = (w_op == 6'h20) | (w_op == 6'h21);
   assign w_mem     = MemRead1_PR | MemWrite1_PR;
   assign w_mis     = w_mem & ((w_half & aluResult1_PR[0]) | (w_word & |aluResult1_PR[1:0]));
   assign w_timeout = r_cnt == CNT_W'(TIMEOUT);
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_req      = 1'b0;
      w_stall    = 1'b0;
      w_abort    = 1'b0;
      if (r_state == IDLE) begin
         w_req   = w_mem & ~w_mis;
         w_stall = w_req & ~dmem_ready;
         if (w_stall) begin
            w_next     = WAIT;
            w_cnt_next = CNT_W'(1);
         end
      end else begin
         w_req = 1'b1;
         if (dmem_ready) begin
            w_next     = IDLE;
            w_cnt_next = '0;
         end else if (w_timeout) begin
            w_abort    = 1'b1;
            w_next     = IDLE;
            w_cnt_next = '0;
         end else begin
            w_stall    = 1'b1;
            w_cnt_next = r_cnt + CNT_W'(1);
         end
      end
   end
   // Reset drops the request immediately, even mid-access.
   assign dmem_req   = w_req & RESET;
   assign Stall_MEM  = w_stall & RESET;
   assign dmem_we    = MemWrite1_PR;
   assign dmem_addr  = {aluResult1_PR[31:2], 2'b00};
   assign dmem_wdata = w_byte ? {4{readDataB1_PR[7:0]}} : w_half ? {2{readDataB1_PR[15:0]}} : readDataB1_PR;
   assign dmem_be    = ~MemWrite1_PR ? 4'hF : w_byte ? 4'b0001 << aluResult1_PR[1:0] :
                       w_half ? (aluResult1_PR[1] ? 4'b1100 : 4'b0011) : 4'hF;
   assign w_bsh      = dmem_rdata >> {aluResult1_PR[1:0], 3'b000};
   assign w_hsh      = dmem_rdata >> {aluResult1_PR[1], 4'b0000};
   assign w_load     = w_byte ? {{24{w_sext & w_bsh[7]}}, w_bsh[7:0]} :
                       w_half ? {{16{w_sext & w_hsh[15]}}, w_hsh[15:0]} : dmem_rdata;
   assign Data1_MEM          = aluResult1_PR;
   assign writeRegister1_MEM = writeRegister1_PR;
   assign do_writeback1_MEM  = do_writeback1_PR & ~MemRead1_PR;
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state           <= IDLE;
         r_cnt             <= '0;
         Data1_WB          <= '0;
         writeRegister1_WB <= '0;
         do_writeback1_WB  <= 1'b0;
         misalign_exc      <= 1'b0;
         bus_err           <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_cnt        <= w_cnt_next;
         misalign_exc <= (r_state == IDLE) & w_mis;
         if (w_abort) bus_err <= 1'b1;
         if (w_stall) do_writeback1_WB <= 1'b0;
         else begin
            Data1_WB          <= MemtoReg1_PR ? w_load : aluResult1_PR;
            writeRegister1_WB <= writeRegister1_PR;
            do_writeback1_WB  <= do_writeback1_PR & ~w_mis & ~w_abort;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus multi-cycle wait, timeout and reset sequences.
module tb_mem_stage;
   logic        CLK = 1'b0, RESET;
   logic [31:0] aluResult1_PR, readDataB1_PR, Instr1_PR, dmem_rdata;
   logic [4:0]  writeRegister1_PR;
   logic        do_writeback1_PR, MemRead1_PR, MemWrite1_PR, MemtoReg1_PR, dmem_ready;
   logic        dmem_req, dmem_we, Stall_MEM, do_writeback1_MEM, do_writeback1_WB, misalign_exc, bus_err;
   logic [31:0] dmem_addr, dmem_wdata, Data1_MEM, Data1_WB;
   logic [3:0]  dmem_be;
   logic [4:0]  writeRegister1_MEM, writeRegister1_WB;
   int tests = 0, failed = 0;

   mem_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
      .CLK(CLK), .RESET(RESET), .aluResult1_PR(aluResult1_PR), .readDataB1_PR(readDataB1_PR),
      .Instr1_PR(Instr1_PR), .writeRegister1_PR(writeRegister1_PR), .do_writeback1_PR(do_writeback1_PR),
      .MemRead1_PR(MemRead1_PR), .MemWrite1_PR(MemWrite1_PR), .MemtoReg1_PR(MemtoReg1_PR),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .Stall_MEM(Stall_MEM),
      .Data1_MEM(Data1_MEM), .writeRegister1_MEM(writeRegister1_MEM), .do_writeback1_MEM(do_writeback1_MEM),
      .Data1_WB(Data1_WB), .writeRegister1_WB(writeRegister1_WB), .do_writeback1_WB(do_writeback1_WB),
      .misalign_exc(misalign_exc), .bus_err(bus_err));

   always #5 CLK = ~CLK;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] alu, d, rdata;
      logic [4:0]  wr;
      logic        wb, mr, mw, m2r, rdy;
      logic        ereq, emis, ewb;
      logic [3:0]  ebe;
      logic [31:0] ewd, edata;
      logic        cbus, cwd, cd;
   } vec_t;
   vec_t vt[$];

   function automatic vec_t mk(input logic [5:0] op, input logic [31:0] alu, d, rdata, input logic [4:0] wr,
                               input logic wb, mr, mw, m2r, rdy, ereq, emis, ewb, input logic [3:0] ebe,
                               input logic [31:0] ewd, edata, input logic cbus, cwd, cd);
      vec_t v;
      v.op = op; v.alu = alu; v.d = d; v.rdata = rdata; v.wr = wr; v.wb = wb; v.mr = mr; v.mw = mw;
      v.m2r = m2r; v.rdy = rdy; v.ereq = ereq; v.emis = emis; v.ewb = ewb; v.ebe = ebe; v.ewd = ewd;
      v.edata = edata; v.cbus = cbus; v.cwd = cwd; v.cd = cd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] alu, d, rdata, input logic [4:0] wr,
                        input logic wb, mr, mw, m2r, rdy);
      Instr1_PR = {op, 26'h0}; aluResult1_PR = alu; readDataB1_PR = d; dmem_rdata = rdata;
      writeRegister1_PR = wr; do_writeback1_PR = wb; MemRead1_PR = mr; MemWrite1_PR = mw;
      MemtoReg1_PR = m2r; dmem_ready = rdy;
   endtask

   initial begin
      int stalls;
      logic st;
      RESET = 1'b0;
      drive(6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_data_wb", Data1_WB, 0);
      chk("rst_wr_wb", 32'(writeRegister1_WB), 0);
      chk("rst_wb_wb", 32'(do_writeback1_WB), 0);
      chk("rst_misalign", 32'(misalign_exc), 0);
      chk("rst_bus_err", 32'(bus_err), 0);
      chk("rst_req", 32'(dmem_req), 0);
      @(negedge CLK) RESET = 1'b1;

      vt.push_back(mk(6'h00, 32'h1234, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 4'hF, 0, 32'h1234, 0, 0, 1));
      vt.push_back(mk(6'h00, 32'hA5A5, 0, 32'hFFFFFFFF, 6, 1, 0, 0, 0, 1, 0, 0, 1, 4'hF, 0, 32'hA5A5, 0, 0, 1));
      vt.push_back(mk(6'h20, 32'h103, 0, 32'h80FFFFFF, 3, 1, 1, 0, 1, 1, 1, 0, 1, 4'hF, 0, 32'hFFFFFF80, 1, 0, 1));
      vt.push_back(mk(6'h24, 32'h103, 0, 32'h80FFFFFF, 3, 1, 1, 0, 1, 1, 1, 0, 1, 4'hF, 0, 32'h00000080, 1, 0, 1));
      vt.push_back(mk(6'h21, 32'h102, 0, 32'h80011234, 4, 1, 1, 0, 1, 1, 1, 0, 1, 4'hF, 0, 32'hFFFF8001, 1, 0, 1));
      vt.push_back(mk(6'h25, 32'h100, 0, 32'h80019234, 4, 1, 1, 0, 1, 1, 1, 0, 1, 4'hF, 0, 32'h00009234, 1, 0, 1));
      vt.push_back(mk(6'h23, 32'h104, 0, 32'hDEADBEEF, 7, 1, 1, 0, 1, 1, 1, 0, 1, 4'hF, 0, 32'hDEADBEEF, 1, 0, 1));
      vt.push_back(mk(6'h20, 32'h010, 0, 32'h1234567F, 2, 1, 1, 0, 1, 1, 1, 0, 1, 4'hF, 0, 32'h0000007F, 1, 0, 1));
      vt.push_back(mk(6'h28, 32'h201, 32'h123456AB, 0, 9, 0, 0, 1, 0, 1, 1, 0, 0, 4'b0010, 32'hABABABAB, 32'h201, 1, 1, 1));
      vt.push_back(mk(6'h29, 32'h200, 32'h0000ABCD, 0, 9, 0, 0, 1, 0, 1, 1, 0, 0, 4'b0011, 32'hABCDABCD, 32'h200, 1, 1, 1));
      vt.push_back(mk(6'h2B, 32'h300, 32'hCAFEF00D, 0, 9, 0, 0, 1, 0, 1, 1, 0, 0, 4'hF, 32'hCAFEF00D, 32'h300, 1, 1, 1));
      vt.push_back(mk(6'h23, 32'h101, 0, 32'h11111111, 1, 1, 1, 0, 1, 1, 0, 1, 0, 4'hF, 0, 0, 0, 0, 0));
      vt.push_back(mk(6'h21, 32'h103, 0, 32'h11111111, 1, 1, 1, 0, 1, 1, 0, 1, 0, 4'hF, 0, 0, 0, 0, 0));
      vt.push_back(mk(6'h29, 32'h201, 32'h5555, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 4'hF, 0, 0, 0, 0, 0));
      vt.push_back(mk(6'h30, 32'h102, 0, 32'h11111111, 1, 1, 1, 0, 1, 1, 0, 1, 0, 4'hF, 0, 0, 0, 0, 0));
      vt.push_back(mk(6'h30, 32'h108, 0, 32'h89ABCDEF, 11, 1, 1, 0, 1, 1, 1, 0, 1, 4'hF, 0, 32'h89ABCDEF, 1, 0, 1));
      vt.push_back(mk(6'h00, 32'h42, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 1, 4'hF, 0, 32'h42, 0, 0, 1));

      foreach (vt[i]) begin
         @(negedge CLK);
         drive(vt[i].op, vt[i].alu, vt[i].d, vt[i].rdata, vt[i].wr, vt[i].wb, vt[i].mr, vt[i].mw, vt[i].m2r, vt[i].rdy);
         #2;
         chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vt[i].ereq));
         chk($sformatf("v%0d_stall", i), 32'(Stall_MEM), 0);
         chk($sformatf("v%0d_fwd_data", i), Data1_MEM, vt[i].alu);
         chk($sformatf("v%0d_fwd_wr", i), 32'(writeRegister1_MEM), 32'(vt[i].wr));
         chk($sformatf("v%0d_fwd_wb", i), 32'(do_writeback1_MEM), 32'(vt[i].wb & ~vt[i].mr));
         if (vt[i].cbus) begin
            chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vt[i].mw));
            chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(vt[i].ebe));
            chk($sformatf("v%0d_addr", i), dmem_addr, vt[i].alu & 32'hFFFFFFFC);
         end
         if (vt[i].cwd) chk($sformatf("v%0d_wdata", i), dmem_wdata, vt[i].ewd);
         @(posedge CLK);
         #1;
         chk($sformatf("v%0d_wb_wb", i), 32'(do_writeback1_WB), 32'(vt[i].ewb));
         chk($sformatf("v%0d_misalign", i), 32'(misalign_exc), 32'(vt[i].emis));
         if (vt[i].cd) begin
            chk($sformatf("v%0d_data_wb", i), Data1_WB, vt[i].edata);
            chk($sformatf("v%0d_wr_wb", i), 32'(writeRegister1_WB), 32'(vt[i].wr));
         end
      end

      // store with three wait cycles; WB must bubble and hold the previous add
      @(negedge CLK) drive(6'h00, 32'h55, 0, 0, 7, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK) drive(6'h29, 32'h202, 32'h0000ABCD, 0, 0, 0, 0, 1, 0, i == 3);
         #2;
         chk($sformatf("sh_req%0d", i), 32'(dmem_req), 1);
         chk($sformatf("sh_be%0d", i), 32'(dmem_be), 32'hC);
         chk($sformatf("sh_wdata%0d", i), dmem_wdata, 32'hABCDABCD);
         chk($sformatf("sh_stall%0d", i), 32'(Stall_MEM), 32'(i < 3));
         @(posedge CLK);
         #1;
         chk($sformatf("sh_wb_wb%0d", i), 32'(do_writeback1_WB), 0);
         if (i < 3) begin
            chk($sformatf("sh_hold_data%0d", i), Data1_WB, 32'h55);
            chk($sformatf("sh_hold_wr%0d", i), 32'(writeRegister1_WB), 7);
         end
      end
      // load completing after two wait cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK) drive(6'h23, 32'h400, 0, i == 2 ? 32'h11223344 : 32'h0, 10, 1, 1, 0, 1, i == 2);
         #2;
         chk($sformatf("lw_stall%0d", i), 32'(Stall_MEM), 32'(i < 2));
         @(posedge CLK);
      end
      #1;
      chk("lw_wait_data", Data1_WB, 32'h11223344);
      chk("lw_wait_wr", 32'(writeRegister1_WB), 10);
      chk("lw_wait_wb", 32'(do_writeback1_WB), 1);

      // timeout: ready never arrives
      stalls = 0;
      st = 1'b1;
      for (int i = 0; i < 12 && st; i++) begin
         @(negedge CLK) drive(6'h23, 32'h500, 0, 0, 13, 1, 1, 0, 1, 0);
         #2;
         st = Stall_MEM;
         if (st) stalls++;
         @(posedge CLK);
      end
      #1;
      chk("to_stall_cycles", 32'(stalls), 4);
      chk("to_bus_err", 32'(bus_err), 1);
      chk("to_wb_wb", 32'(do_writeback1_WB), 0);
      @(negedge CLK) drive(6'h00, 32'h77, 0, 0, 8, 1, 0, 0, 0, 0);
      #2;
      chk("to_resume_stall", 32'(Stall_MEM), 0);
      @(posedge CLK);
      #1;
      chk("to_resume_data", Data1_WB, 32'h77);
      chk("to_resume_wb", 32'(do_writeback1_WB), 1);
      chk("to_sticky", 32'(bus_err), 1);

      // asynchronous reset while waiting
      @(negedge CLK) drive(6'h23, 32'h600, 0, 0, 14, 1, 1, 0, 1, 0);
      @(posedge CLK);
      #3;
      RESET = 1'b0;
      #1;
      chk("rw_req", 32'(dmem_req), 0);
      chk("rw_stall", 32'(Stall_MEM), 0);
      chk("rw_bus_err", 32'(bus_err), 0);
      chk("rw_data_wb", Data1_WB, 0);
      drive(6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK) RESET = 1'b1;
      #2;
      chk("rel_req", 32'(dmem_req), 0);
      @(posedge CLK);
      #1;
      chk("rel_data_wb", Data1_WB, 0);
      chk("rel_wr_wb", 32'(writeRegister1_WB), 0);
      chk("rel_wb_wb", 32'(do_writeback1_WB), 0);
      chk("rel_misalign", 32'(misalign_exc), 0);
      chk("rel_bus_err", 32'(bus_err), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
